float_add_arbiter: RTL
======================

# float_add_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle `float_adder_e4m3` instance between `NUM_REQ` requesters. It accepts one operand pair per grant over a valid/ready handshake and launches the adder by pulsing the adder's active-high restart input. It waits for the adder's valid flag, then returns the sum tagged with the requester index on a single response channel. It sits between the FP8 compute clients and the shared adder.

## Interface
- `NUM_REQ`, default 4: number of requesters; supported range 2..8.
- `TIMEOUT`, default 15: maximum WAIT cycles before abort. Only used with `ADDER_TIMEOUT_EN`.
- `clock`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-low; sampled on the `clock` rising edge.
- `req_valid`  in  NUM_REQ: per-requester request valid.
- `req_a`  in  8*NUM_REQ: E4M3 operand A; requester i uses bits [8i+7:8i].
- `req_b`  in  8*NUM_REQ: E4M3 operand B, same packing as `req_a`.
- `req_ready`  out  NUM_REQ: one-hot grant/accept strobe.
- `resp_valid`  out  1: response valid.
- `resp_ready`  in  1: response consumer ready.
- `resp_y`  out  8: E4M3 sum.
- `resp_id`  out  $clog2(NUM_REQ): index of the requester that owns the response.
- `resp_err`  out  1: adder timeout. Only ever asserted with `ADDER_TIMEOUT_EN`.
- `add_a`, `add_b`  out  8 each: operands to the adder.
- `add_start`  out  1: drives the adder's active-high reset; 1 holds or restarts the adder, 0 lets it compute.
- `add_y`  in  8: adder result.
- `add_valid`  in  1: adder `is_output_valid`.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Grant the first asserted `req_valid` searching from `ptr`, wrapping modulo NUM_REQ.
  - In the same cycle, drive `req_ready` one-hot to the granted requester. This is combinational from `req_valid` and `ptr`.
  - On the clock edge, latch that requester's a/b into `add_a`/`add_b`, latch its index into `resp_id`, and go to LAUNCH.
  - With no `req_valid` asserted, `req_ready` is 0 and the FSM stays in IDLE.
- LAUNCH: `add_start`=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - `add_start`=0.
  - `add_valid` is ignored in the first WAIT cycle, which masks a stale valid.
  - From the second WAIT cycle on, `add_valid`=1 latches `add_y` into `resp_y`, clears `resp_err`, and moves to RESP.
- RESP:
  - `resp_valid`=1 with `resp_y`, `resp_id` and `resp_err` held stable.
  - On `resp_valid & resp_ready`, set `ptr` = granted index + 1 (mod NUM_REQ) and return to IDLE.
- `add_a`/`add_b` stay stable from LAUNCH until the next grant.
- `add_start`=1 in IDLE, LAUNCH and RESP, and 0 only in WAIT.
- Fairness: a requester holding `req_valid` continuously is granted within NUM_REQ grants.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_y`=0, `resp_id`=0, `resp_err`=0, `add_a`=`add_b`=0, `add_start`=1, `ptr`=0, state IDLE.
- Reset mid-operation: abort immediately and return all outputs to their reset values. An accepted but unanswered request is dropped with no response.
- Cycle timeline, for an adder producing `add_valid` L cycles after `add_start` falls (L≥2):
  - Grant in cycle 0.
  - LAUNCH in cycle 1.
  - WAIT in cycles 2..1+L.
  - `resp_valid` rises in cycle 2+L.
  - Minimum IDLE-to-IDLE time is L+3 cycles with `resp_ready` held at 1.
- Backpressure: `resp_ready` low holds RESP indefinitely, and no new grant is issued.
- A requester dropping `req_valid` in the grant cycle is not granted; the grant is combinational.
- Only one request is in flight at any time.

## Configuration
- `ADDER_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs alongside WAIT.
  - If `add_valid` has not been seen after `TIMEOUT` WAIT cycles, go to RESP with `resp_y`=8'h00 and `resp_err`=1.
  - The counter clears on entry to WAIT.
- `ADDER_TIMEOUT_EN` undefined:
  - No counter is built; WAIT has no exit other than `add_valid`.
  - `resp_err` is tied to 0.

## Test plan
- Single request: requester 0 sends a=8'h40, b=8'h40 -> one response, `resp_y`=8'h48, `resp_id`=0, `resp_err`=0. Also check that `req_ready[0]` pulses exactly one cycle.
- Round-robin: all four requesters present simultaneously with (8'h28,8'h10), (8'h50,8'h10), (8'h50,8'hD0), (8'hC8,8'hD0) -> responses arrive in order id 0,1,2,3 with y = 8'h29, 8'h50, 8'h00, 8'hD4.
- Rotation: requester 1 and requester 3 held valid continuously -> grants alternate 1,3,1,3. Also check that `ptr` advances only on the response handshake.
- Backpressure: hold `resp_ready`=0 for 10 cycles after `resp_valid` -> `resp_y`, `resp_id` and `resp_valid` stay stable, no `req_ready` pulses, and `add_start` stays 1.
- Reset mid-WAIT: drive `reset`=0 for one cycle -> next cycle all outputs at reset values and no response for the dropped request. A subsequent request 8'h41+8'hC0 -> 8'h28.
- Timeout (`ADDER_TIMEOUT_EN`, `TIMEOUT`=15): an adder model that never asserts valid -> `resp_valid` rises 16 cycles after LAUNCH with `resp_err`=1 and `resp_y`=8'h00.

Source files
------------

// File: rtl/float_add_arbiter_if.sv
// Bundle between the FP8 clients, the float_add_arbiter and the shared
// float_adder_e4m3. The slave modport is the arbiter's view; the master
// modport is the environment (clients, response consumer and adder).
interface float_add_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [7:0]           resp_y;
  logic [IDW-1:0]       resp_id;
  logic                 resp_err;
  logic [7:0]           add_a;
  logic [7:0]           add_b;
  logic                 add_start;
  logic [7:0]           add_y;
  logic                 add_valid;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, add_y, add_valid,
    output req_ready, resp_valid, resp_y, resp_id, resp_err,
           add_a, add_b, add_start
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, add_y, add_valid,
    input  req_ready, resp_valid, resp_y, resp_id, resp_err,
           add_a, add_b, add_start
  );
endinterface

// File: rtl/float_add_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle E4M3 adder between
// NUM_REQ requesters. One request is in flight at a time: grant in IDLE,
// pulse the adder restart in LAUNCH, wait for its valid in WAIT, and hold
// the tagged result in RESP until the consumer takes it.
// Optional feature: define ADDER_TIMEOUT_EN to abort WAIT after TIMEOUT
// cycles with resp_err=1 and resp_y=0.
module float_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset,
  float_add_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     a_q, a_d, b_q, b_d, y_q, y_d;
  logic           err_q, err_d;
  logic           first_q, first_d;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  int             j;

`ifdef ADDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]  tmo_q, tmo_d;
`endif

  // First asserted request at or after ptr, wrapping around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any && bus.req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

  // One-hot accept strobe, only while idle.
  always_comb begin
    gnt_oh = '0;
    if (state_q == IDLE && gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  // Next-state and datapath capture for the four-phase sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    err_d   = err_q;
    first_d = first_q;
`ifdef ADDER_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          a_d     = bus.req_a[8*int'(gnt_idx) +: 8];
          b_d     = bus.req_b[8*int'(gnt_idx) +: 8];
          id_d    = gnt_idx;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // Arm the stale-valid mask for the first WAIT cycle.
        first_d = 1'b1;
`ifdef ADDER_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        first_d = 1'b0;
        if (!first_q && bus.add_valid) begin
          y_d     = bus.add_y;
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef ADDER_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          y_d     = 8'h00;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.resp_ready) begin
          ptr_d   = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and holding registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      y_q     <= 8'h00;
      err_q   <= 1'b0;
      first_q <= 1'b0;
`ifdef ADDER_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      err_q   <= err_d;
      first_q <= first_d;
`ifdef ADDER_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.req_ready  = gnt_oh;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_y     = y_q;
  assign bus.resp_id    = id_q;
`ifdef ADDER_TIMEOUT_EN
  assign bus.resp_err   = err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif
  assign bus.add_a      = a_q;
  assign bus.add_b      = b_q;
  // The adder only runs while we are waiting on it.
  assign bus.add_start  = (state_q != WAIT);
endmodule
